// File: rtl/detect_square_pkg.sv
`default_nettype none
// ============================================================================
// Module      : detect_square_pkg
// Description : Shared types and constants for the detect_square block.
// Revision    : 1.0 - initial release
// ============================================================================
package detect_square_pkg;

  localparam int COORD_W = 12;

  // Initial value of the running minimum; any real coordinate replaces it.
  localparam logic [COORD_W-1:0] COORD_MIN_INIT = 12'hFFF;

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    SCAN      = 2'd1,
    REPORT    = 2'd2
  } detect_square_state_t;

endpackage
`default_nettype wire

// File: rtl/vga_if.sv
`default_nettype none
// ============================================================================
// Module      : vga_if
// Description : VGA pixel stream bundle (timing counters, syncs, blanks, rgb).
// Revision    : 1.0 - initial release
// ============================================================================
interface vga_if;
  logic [11:0] hcount;
  logic [11:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface
`default_nettype wire

// File: rtl/square_bbox_acc.sv
`default_nettype none
// ============================================================================
// Module      : square_bbox_acc
// Description : Running min/max bounding-box accumulator with hit flag.
//               clear has priority over sample_en.
// Revision    : 1.0 - initial release
// ============================================================================
module square_bbox_acc
  import detect_square_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_clear,
  input  logic               i_sample_en,
  input  logic [COORD_W-1:0] i_x,
  input  logic [COORD_W-1:0] i_y,
  output logic [COORD_W-1:0] o_xmin,
  output logic [COORD_W-1:0] o_xmax,
  output logic [COORD_W-1:0] o_ymin,
  output logic [COORD_W-1:0] o_ymax,
  output logic               o_hit
);

  logic [COORD_W-1:0] r_xmin, r_xmax, r_ymin, r_ymax;
  logic               r_hit;

  // Track extremes of every sampled coordinate since the last clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_xmin <= COORD_MIN_INIT;
      r_ymin <= COORD_MIN_INIT;
      r_xmax <= '0;
      r_ymax <= '0;
      r_hit  <= 1'b0;
    end else if (i_clear) begin
      r_xmin <= COORD_MIN_INIT;
      r_ymin <= COORD_MIN_INIT;
      r_xmax <= '0;
      r_ymax <= '0;
      r_hit  <= 1'b0;
    end else if (i_sample_en) begin
      if (i_x < r_xmin) r_xmin <= i_x;
      if (i_x > r_xmax) r_xmax <= i_x;
      if (i_y < r_ymin) r_ymin <= i_y;
      if (i_y > r_ymax) r_ymax <= i_y;
      r_hit <= 1'b1;
    end
  end

  assign o_xmin = r_xmin;
  assign o_xmax = r_xmax;
  assign o_ymin = r_ymin;
  assign o_ymax = r_ymax;
  assign o_hit  = r_hit;

endmodule
`default_nettype wire

// File: rtl/detect_square.sv
`default_nettype none
// ============================================================================
// Module      : detect_square
// Description : Measures the bounding box of pixels drawn in MATCH_COLOR and
//               reports it once per frame; forwards the VGA stream with one
//               cycle of latency.
//               Optional macro DETECT_SQUARE_OVERLAY_EN draws the last
//               reported box outline in OUTLINE_COLOR on the output stream.
// Revision    : 1.0 - initial release
// ============================================================================
module detect_square
  import detect_square_pkg::*;
#(
  parameter logic [11:0] MATCH_COLOR   = 12'hf_0_f,
  parameter logic [11:0] OUTLINE_COLOR = 12'h0_f_0
) (
  input  logic        clk,
  input  logic        rst,
  vga_if.in           vga_in,
  vga_if.out          vga_out,
  output logic [11:0] xpos_found,
  output logic [11:0] ypos_found,
  output logic [11:0] width_found,
  output logic [11:0] height_found,
  output logic        found,
  output logic        frame_done
);

  detect_square_state_t r_state, w_state_nxt;

  logic        r_vblnk_q;
  logic        w_vblnk_rise;
  logic        w_active;
  logic        w_match;
  logic        w_clear;
  logic        w_sample_en;
  logic        w_report;
  logic [11:0] w_xmin, w_xmax, w_ymin, w_ymax;
  logic        w_hit;
  logic [11:0] w_rgb_nxt;

  assign w_vblnk_rise = vga_in.vblnk && !r_vblnk_q;
  assign w_active     = !vga_in.hblnk && !vga_in.vblnk;
  assign w_match      = w_active && (vga_in.rgb == MATCH_COLOR);

  // Delayed vblnk for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_vblnk_q <= 1'b0;
    else     r_vblnk_q <= vga_in.vblnk;
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= WAIT_SYNC;
    else     r_state <= w_state_nxt;
  end

  // FSM next state and accumulator controls; the first rise after reset only aligns to a frame.
  always_comb begin
    w_state_nxt = r_state;
    w_clear     = 1'b0;
    w_sample_en = 1'b0;
    w_report    = 1'b0;
    unique case (r_state)
      WAIT_SYNC: begin
        if (w_vblnk_rise) begin
          w_clear     = 1'b1;
          w_state_nxt = SCAN;
        end
      end
      SCAN: begin
        w_sample_en = w_match;
        if (w_vblnk_rise) w_state_nxt = REPORT;
      end
      REPORT: begin
        w_report    = 1'b1;
        w_clear     = 1'b1;
        w_state_nxt = SCAN;
      end
      default: w_state_nxt = WAIT_SYNC;
    endcase
  end

  square_bbox_acc u_acc (
    .clk         (clk),
    .rst         (rst),
    .i_clear     (w_clear),
    .i_sample_en (w_sample_en),
    .i_x         (vga_in.hcount),
    .i_y         (vga_in.vcount),
    .o_xmin      (w_xmin),
    .o_xmax      (w_xmax),
    .o_ymin      (w_ymin),
    .o_ymax      (w_ymax),
    .o_hit       (w_hit)
  );

  // Result registers: loaded in REPORT, held otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xpos_found   <= '0;
      ypos_found   <= '0;
      width_found  <= '0;
      height_found <= '0;
      found        <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      frame_done <= w_report;
      if (w_report) begin
        found <= w_hit;
        if (w_hit) begin
          xpos_found   <= w_xmin;
          ypos_found   <= w_ymin;
          width_found  <= w_xmax - w_xmin;
          height_found <= w_ymax - w_ymin;
        end else begin
          xpos_found   <= '0;
          ypos_found   <= '0;
          width_found  <= '0;
          height_found <= '0;
        end
      end
    end
  end

`ifdef DETECT_SQUARE_OVERLAY_EN
  logic [11:0] w_xr, w_yb;
  logic        w_in_x, w_in_y, w_on_vert, w_on_horz;

  assign w_xr      = xpos_found + width_found;
  assign w_yb      = ypos_found + height_found;
  assign w_in_x    = (vga_in.hcount >= xpos_found) && (vga_in.hcount <= w_xr);
  assign w_in_y    = (vga_in.vcount >= ypos_found) && (vga_in.vcount <= w_yb);
  assign w_on_vert = ((vga_in.hcount == xpos_found) || (vga_in.hcount == w_xr)) && w_in_y;
  assign w_on_horz = ((vga_in.vcount == ypos_found) || (vga_in.vcount == w_yb)) && w_in_x;
  assign w_rgb_nxt = (found && w_active && (w_on_vert || w_on_horz)) ? OUTLINE_COLOR : vga_in.rgb;
`else
  logic [11:0] w_unused_outline;

  // The outline colour only matters when the overlay is built in.
  assign w_unused_outline = OUTLINE_COLOR;
  assign w_rgb_nxt        = vga_in.rgb;
`endif

  // One-cycle pipeline register for the forwarded stream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vga_out.hcount <= '0;
      vga_out.vcount <= '0;
      vga_out.hsync  <= 1'b0;
      vga_out.vsync  <= 1'b0;
      vga_out.hblnk  <= 1'b0;
      vga_out.vblnk  <= 1'b0;
      vga_out.rgb    <= '0;
    end else begin
      vga_out.hcount <= vga_in.hcount;
      vga_out.vcount <= vga_in.vcount;
      vga_out.hsync  <= vga_in.hsync;
      vga_out.vsync  <= vga_in.vsync;
      vga_out.hblnk  <= vga_in.hblnk;
      vga_out.vblnk  <= vga_in.vblnk;
      vga_out.rgb    <= w_rgb_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_detect_square.sv
`default_nettype none
// ============================================================================
// Module      : tb_detect_square
// Description : Directed self-checking bench for detect_square.
//               Expectations follow DETECT_SQUARE_OVERLAY_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_detect_square;

  localparam logic [11:0] MATCH   = 12'hf0f;
  localparam logic [11:0] OUTLINE = 12'h0f0;
  localparam logic [11:0] OTHER   = 12'h123;

  logic        clk;
  logic        rst;
  logic [11:0] xpos_found, ypos_found, width_found, height_found;
  logic        found, frame_done;
  int          vectors;
  int          miscompares;

  vga_if vin ();
  vga_if vout ();

  detect_square #(
    .MATCH_COLOR   (MATCH),
    .OUTLINE_COLOR (OUTLINE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .vga_in       (vin),
    .vga_out      (vout),
    .xpos_found   (xpos_found),
    .ypos_found   (ypos_found),
    .width_found  (width_found),
    .height_found (height_found),
    .found        (found),
    .frame_done   (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One pixel per clock; after the edge the forwarded stream must equal the driven pixel.
  task automatic drive(input logic [11:0] h, input logic [11:0] v, input logic [11:0] c,
                       input logic hb, input logic vb);
    vin.hcount = h;
    vin.vcount = v;
    vin.rgb    = c;
    vin.hblnk  = hb;
    vin.vblnk  = vb;
    vin.hsync  = h[0];
    vin.vsync  = v[1];
    @(posedge clk);
    #1;
    chk("vga_out_ctrl", {vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk},
                        {h, v, h[0], v[1], hb, vb});
    if (hb || vb) chk("vga_out_rgb_blank", {36'd0, vout.rgb}, {36'd0, c});
  endtask

  task automatic draw_rect(input int x, input int y, input int w, input int h);
    for (int yy = y; yy <= y + h; yy++)
      for (int xx = x; xx <= x + w; xx++)
        drive(12'(xx), 12'(yy), MATCH, 1'b0, 1'b0);
  endtask

  // vblnk rise held 5 cycles; report expected on 2nd edge only, when exp_rep is set.
  task automatic frame_end(input bit exp_rep, input logic [11:0] ex, input logic [11:0] ey,
                           input logic [11:0] ew, input logic [11:0] eh, input logic ef);
    drive(12'd0, 12'd700, OTHER, 1'b1, 1'b1);
    chk("frame_done_edgeN", {47'd0, frame_done}, 48'd0);
    drive(12'd1, 12'd700, OTHER, 1'b1, 1'b1);
    chk("frame_done_edgeN1", {47'd0, frame_done}, {47'd0, exp_rep});
    if (exp_rep) begin
      chk("result_xywh", {xpos_found, ypos_found, width_found, height_found}, {ex, ey, ew, eh});
      chk("result_found", {47'd0, found}, {47'd0, ef});
    end
    for (int i = 0; i < 3; i++) begin
      drive(12'(i + 2), 12'd700, OTHER, 1'b1, 1'b1);
      chk("frame_done_held", {47'd0, frame_done}, 48'd0);
    end
    drive(12'd0, 12'd0, OTHER, 1'b1, 1'b0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    vin.hcount  = 12'd7;
    vin.vcount  = 12'd9;
    vin.rgb     = MATCH;
    vin.hsync   = 1'b1;
    vin.vsync   = 1'b1;
    vin.hblnk   = 1'b0;
    vin.vblnk   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_vga_out", {vout.hcount, vout.rgb, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk},
                         48'd0);
    chk("reset_results", {xpos_found, ypos_found, width_found, height_found},
                         {12'd0, 12'd0, 12'd0, 12'd0});
    chk("reset_flags", {46'd0, found, frame_done}, 48'd0);
    rst = 1'b0;

    // Frame 0: first rise only synchronises.
    draw_rect(150, 100, 40, 8);
    frame_end(1'b0, 12'd0, 12'd0, 12'd0, 12'd0, 1'b0);

    // Frame 1: rectangle with distractors.
    drive(12'd10, 12'd10, MATCH, 1'b1, 1'b0);
    drive(12'd300, 12'd300, OTHER, 1'b0, 1'b0);
    draw_rect(150, 100, 40, 8);
    frame_end(1'b1, 12'd150, 12'd100, 12'd40, 12'd8, 1'b1);

    // Frame 2: overlay probes, matches only during hblnk.
    drive(12'd150, 12'd100, OTHER, 1'b0, 1'b0);
`ifdef DETECT_SQUARE_OVERLAY_EN
    chk("overlay_tl", {36'd0, vout.rgb}, {36'd0, OUTLINE});
`else
    chk("overlay_tl", {36'd0, vout.rgb}, {36'd0, OTHER});
`endif
    drive(12'd190, 12'd108, OTHER, 1'b0, 1'b0);
`ifdef DETECT_SQUARE_OVERLAY_EN
    chk("overlay_br", {36'd0, vout.rgb}, {36'd0, OUTLINE});
`else
    chk("overlay_br", {36'd0, vout.rgb}, {36'd0, OTHER});
`endif
    drive(12'd150, 12'd104, OTHER, 1'b0, 1'b0);
`ifdef DETECT_SQUARE_OVERLAY_EN
    chk("overlay_left", {36'd0, vout.rgb}, {36'd0, OUTLINE});
`else
    chk("overlay_left", {36'd0, vout.rgb}, {36'd0, OTHER});
`endif
    drive(12'd170, 12'd104, OTHER, 1'b0, 1'b0);
    chk("overlay_interior", {36'd0, vout.rgb}, {36'd0, OTHER});
    drive(12'd191, 12'd100, OTHER, 1'b0, 1'b0);
    chk("overlay_outside", {36'd0, vout.rgb}, {36'd0, OTHER});
    drive(12'd150, 12'd100, OTHER, 1'b1, 1'b0);
    drive(12'd5, 12'd5, MATCH, 1'b1, 1'b0);
    drive(12'd6, 12'd6, MATCH, 1'b1, 1'b0);
    frame_end(1'b1, 12'd0, 12'd0, 12'd0, 12'd0, 1'b0);

    // Frame 3: single corner pixel.
    drive(12'd0, 12'd0, MATCH, 1'b0, 1'b0);
    drive(12'd1, 12'd0, OTHER, 1'b0, 1'b0);
    frame_end(1'b1, 12'd0, 12'd0, 12'd0, 12'd0, 1'b1);

    // Frame 4: empty.
    drive(12'd20, 12'd20, OTHER, 1'b0, 1'b0);
    frame_end(1'b1, 12'd0, 12'd0, 12'd0, 12'd0, 1'b0);

    // Frame 5: rectangle again, then reset mid-frame 6.
    draw_rect(150, 100, 40, 8);
    frame_end(1'b1, 12'd150, 12'd100, 12'd40, 12'd8, 1'b1);
    draw_rect(150, 100, 40, 2);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_results", {xpos_found, ypos_found, width_found, height_found},
                             {12'd0, 12'd0, 12'd0, 12'd0});
    chk("async_rst_flags", {22'd0, found, frame_done, vout.rgb, vout.hcount}, 48'd0);
    @(posedge clk);
    #3 rst = 1'b0;
    draw_rect(150, 103, 40, 5);
    frame_end(1'b0, 12'd0, 12'd0, 12'd0, 12'd0, 1'b0);

    // Frame 7: extremes of both axes.
    drive(12'd4095, 12'd4095, MATCH, 1'b0, 1'b0);
    drive(12'd0, 12'd0, MATCH, 1'b0, 1'b0);
    frame_end(1'b1, 12'd0, 12'd0, 12'd4095, 12'd4095, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/detect_square.md
# detect_square

Stream reader for the VGA pipeline: it watches the `vga_if` pixel stream produced by the drawing stages and measures the on-screen object they drew. Every active pixel whose `rgb` equals a configured colour feeds a bounding-box accumulator. At each frame end the block reports position, width and height to game/control logic. The stream itself is forwarded with one cycle of latency, so the block drops into the pipeline anywhere after the draw stages.

## Interface
- `MATCH_COLOR`, default 12'hf_0_f: pixel colour counted as part of the object.
- `OUTLINE_COLOR`, default 12'h0_f_0: outline colour. Used only with the overlay macro.
- `clk` in 1: pixel clock. One clock domain.
- `rst` in 1: asynchronous, active-high reset.
- `vga_in` `vga_if.in`: incoming stream (`hcount`, `vcount`, `hsync`, `vsync`, `hblnk`, `vblnk`, `rgb`).
- `vga_out` `vga_if.out`: forwarded stream.
- `xpos_found` out 12: leftmost matching `hcount`.
- `ypos_found` out 12: topmost matching `vcount`.
- `width_found` out 12: xmax − xmin (same inclusive-span convention the draw stages use).
- `height_found` out 12: ymax − ymin.
- `found` out 1: at least one matching pixel in the last reported frame.
- `frame_done` out 1: one-cycle pulse when the result outputs update.

## Operation
- Active pixel: `!hblnk && !vblnk`. A pixel matches when it is active and `rgb == MATCH_COLOR`. A matching colour during blanking is ignored.
- Accumulators:
  - `xmin`/`ymin` clear to 12'hFFF.
  - `xmax`/`ymax` clear to 0.
  - `hit` clears to 0.
  - On each match: `xmin = min(xmin, hcount)`, `xmax = max(xmax, hcount)`, same for y; `hit <= 1`.
- `vblnk_rise` = `vga_in.vblnk && !vblnk_q`, where `vblnk_q` is a registered copy of `vblnk`.
- FSM states:
  - **WAIT_SYNC** (reset state): accumulators frozen. On `vblnk_rise`: clear accumulators, go to SCAN.
  - **SCAN**: accumulate matches. On `vblnk_rise`: go to REPORT.
  - **REPORT** (exactly one cycle):
    - If `hit`: results load `xmin`, `ymin`, `xmax−xmin`, `ymax−ymin`; `found <= 1`.
    - Else: results load 0; `found <= 0`.
    - `frame_done <= 1`; accumulators clear; go to SCAN.
- Arithmetic: all coordinates unsigned 12-bit. Subtraction cannot underflow when `hit` is set.
- Results hold their value until the next REPORT.

## Timing
- `vga_out` carries every `vga_in` field registered with 1-cycle latency, rgb included unless overlay modifies it.
- `frame_done` and result updates occur 2 cycles after the cycle in which `vga_in.vblnk` first goes high:
  - Edge N samples the rise; FSM enters REPORT.
  - Edge N+1 loads the results and raises `frame_done`.
  - Edge N+2 drops `frame_done`.
- Reset values:
  - All `vga_out` fields 0.
  - Results 0; `found` 0; `frame_done` 0.
  - `vblnk_q` 0; state WAIT_SYNC.
- Reset mid-frame: the partial frame is discarded. The first `frame_done` comes at the second `vblnk` rise after reset release (the first rise only synchronises).
- Object touching 0 or 4095 on either axis: reported exactly, no saturation.
- A `vblnk` held high for several cycles produces one report per rise.

## Configuration
- `DETECT_SQUARE_OVERLAY_EN` defined:
  - The output `rgb` becomes `OUTLINE_COLOR` on the bounding-box border of the last reported result, when `found == 1`. Border pixels:
    - `hcount` ∈ {`xpos_found`, `xpos_found + width_found`} with `vcount` inside [`ypos_found`, `ypos_found + height_found`];
    - or `vcount` ∈ {`ypos_found`, `ypos_found + height_found`} with `hcount` inside [`xpos_found`, `xpos_found + width_found`].
  - Only active pixels are modified.
- `DETECT_SQUARE_OVERLAY_EN` undefined: `rgb` passes through unchanged. The overlay logic is absent.

## Structure
- Shared VGA package holds:
  - `detect_square_state_t` enum {WAIT_SYNC, SCAN, REPORT};
  - `COORD_MIN_INIT` = 12'hFFF.
- One sub-module, `square_bbox_acc`: min/max/hit accumulator with `clear` and `sample_en` inputs, instantiated once.

## Test plan
- **Rectangle:** draw stage at x=150, y=100, width=40, size=8 in `MATCH_COLOR` for two frames -> after the second `vblnk` rise: `xpos_found`=150, `ypos_found`=100, `width_found`=40, `height_found`=8, `found`=1.
- **Empty frame:** no matching pixels -> `found`=0, all result outputs 0, `frame_done` still pulses once.
- **Corner pixel:** single match at (0,0) -> results 0,0,0,0 with `found`=1. Matching `rgb` injected only during `hblnk` -> `found`=0.
- **Report timing:** measure from `vblnk` rise -> `frame_done` high exactly one cycle, on the 2nd edge after the rise; `vga_out` equals `vga_in` delayed 1 cycle on all fields.
- **Reset mid-frame:** `rst` pulsed mid-frame (async, between edges) -> outputs 0 immediately; no `frame_done` at the next `vblnk` rise; valid report at the following one.
- **Overlay (`DETECT_SQUARE_OVERLAY_EN`):** after the rectangle report, next frame pixel (150,100) and (190,108) output 12'h0_f_0; interior (170,104) unchanged. Same check with the macro undefined -> `rgb` unchanged everywhere.
